// File: rtl/line_memory.sv
// Line-granular backing memory: write-backs update the array immediately,
// line reads are snapshotted at accept time and returned in order after a
// fixed latency, held until the requester acknowledges them.
module line_memory #(
  parameter int PA_WIDTH  = 32,
  parameter int N_BYTES   = 16,
  parameter int MEM_LINES = 256,
  parameter int ID_WIDTH  = 2,
  parameter int LATENCY   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic [PA_WIDTH-1:0]   i_addr,
  input  logic [N_BYTES*8-1:0]  i_data,
  input  logic                  i_write,
  input  logic                  i_ack,
  output logic                  o_enable,
  output logic [N_BYTES*8-1:0]  o_data,
  output logic [ID_WIDTH-1:0]   o_id_request,
  output logic [ID_WIDTH-1:0]   o_id_response,
  output logic                  o_full
);

  localparam int LINE_WIDTH = N_BYTES * 8;
  localparam int OFFSET     = $clog2(N_BYTES);
  localparam int INDEX_W    = $clog2(MEM_LINES);
  localparam int DEPTH      = 2 ** ID_WIDTH;
  localparam int OCC_W      = ID_WIDTH + 1;
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  logic [LINE_WIDTH-1:0] mem_q [MEM_LINES];

  logic [DEPTH-1:0]      valid_q;
  logic [CNT_W-1:0]      cnt_q  [DEPTH];
  logic [LINE_WIDTH-1:0] snap_q [DEPTH];

  logic [ID_WIDTH-1:0]   head_q, head_d;
  logic [ID_WIDTH-1:0]   tail_q, tail_d;
  logic [OCC_W-1:0]      occ_q,  occ_d;

  logic                  full;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  ack_fire;
  logic                  resp_valid;
  logic [INDEX_W-1:0]    line_idx;
  logic                  unused_addr;

  // Offset and upper alias bits are intentionally ignored.
  assign unused_addr = ^i_addr;
  assign line_idx    = i_addr[OFFSET +: INDEX_W];

  assign full       = (occ_q == OCC_W'(DEPTH));
  assign rd_accept  = i_enable && !i_write && !full;
  assign wr_accept  = i_enable && i_write;
  assign resp_valid = valid_q[head_q] && (cnt_q[head_q] == '0);
  assign ack_fire   = i_ack && resp_valid;

  // Pointer and occupancy next-state.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (rd_accept) tail_d = tail_q + 1'b1;
    if (ack_fire)  head_d = head_q + 1'b1;
    if (rd_accept && !ack_fire)      occ_d = occ_q + 1'b1;
    else if (!rd_accept && ack_fire) occ_d = occ_q - 1'b1;
  end

  // Pointer, occupancy and slot-valid registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      valid_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      if (rd_accept) valid_q[tail_q] <= 1'b1;
      if (ack_fire)  valid_q[head_q] <= 1'b0;
    end
  end

  // Countdown and snapshot per slot; the accept edge itself counts as the
  // first latency cycle, so the countdown is loaded with LATENCY-1.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (cnt_q[i] != '0)) cnt_q[i] <= cnt_q[i] - 1'b1;
    end
    if (rd_accept) begin
      cnt_q[tail_q]  <= CNT_W'(LATENCY - 1);
      snap_q[tail_q] <= mem_q[line_idx];
    end
  end

  // Line storage; not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem_q[line_idx] <= i_data;
  end

  assign o_enable      = resp_valid;
  assign o_data        = resp_valid ? snap_q[head_q] : '0;
  assign o_id_response = resp_valid ? head_q : '0;
  assign o_id_request  = tail_q;
  assign o_full        = full;

endmodule
